// File: rtl/byte_packer_pkg.sv
// Shared encodings, FSM states and mode decode for the byte packer.
package byte_packer_pkg;

  typedef enum logic [1:0] {
    MODE_1B = 2'b00,
    MODE_2B = 2'b01,
    MODE_4B = 2'b10,
    MODE_8B = 2'b11
  } mode_e;

  // HOLD means the output register owns a word that has not left yet.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } bp_state_e;

  // Word size in bytes selected by a mode code.
  function automatic logic [3:0] mode_bytes(input logic [1:0] m);
    case (m)
      MODE_1B: mode_bytes = 4'd1;
      MODE_2B: mode_bytes = 4'd2;
      MODE_4B: mode_bytes = 4'd4;
      default: mode_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/byte_packer_if.sv
// Byte-in / word-out bus of the packer; master is the environment, slave the packer.
interface byte_packer_if #(
  parameter int MAX_BYTES = 4
) ();
  localparam int OUT_W = 8 * MAX_BYTES;

  logic             enb;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic [1:0]       mode;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [3:0]       out_bytes;
  logic             mode_err;

  modport master (
    output enb, in_valid, in_data, mode, flush, out_ready,
    input  in_ready, out_valid, out_data, out_bytes, mode_err
  );

  modport slave (
    input  enb, in_valid, in_data, mode, flush, out_ready,
    output in_ready, out_valid, out_data, out_bytes, mode_err
  );
endinterface

// File: rtl/byte_packer_outreg.sv
// Output holding register: keeps a finished word stable until the consumer takes it.
module byte_packer_outreg #(
  parameter int OUT_W = 32
) (
  input  logic             clk8,
  input  logic             rst,
  input  logic             i_enb,
  input  logic             i_load,
  input  logic [OUT_W-1:0] i_data,
  input  logic [3:0]       i_bytes,
  input  logic             i_out_ready,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data,
  output logic [3:0]       o_bytes
);

  logic             r_valid;
  logic [OUT_W-1:0] r_data;
  logic [3:0]       r_bytes;

  // Load wins over take, so a word taken on the same edge a new one lands keeps valid high.
  always_ff @(posedge clk8) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_bytes <= 4'd0;
    end else if (i_enb) begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
        r_bytes <= i_bytes;
      end else if (r_valid && i_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_bytes = r_bytes;

endmodule

// File: rtl/byte_packer.sv
// Packs a serial byte stream MSB-first into 1/2/4/8-byte words with flush support.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int MAX_BYTES = 4
) (
  input  logic          clk8,
  input  logic          rst,
  byte_packer_if.slave  bp
);

  localparam int OUT_W = 8 * MAX_BYTES;

  logic [3:0]       r_cnt;
  logic [3:0]       r_n;
  logic             r_flush_pend;
  logic             r_mode_err;
  logic [OUT_W-1:0] r_acc;
  bp_state_e        r_state;
  bp_state_e        w_state_nxt;

  logic             w_stall;
  logic             w_in_ready;
  logic             w_acc;
  logic             w_flush;
  logic             w_start;
  logic             w_bad_mode;
  logic             w_complete;
  logic             w_load;
  logic [3:0]       w_mode_n;
  logic [3:0]       w_n;
  logic [3:0]       w_cnt_inc;
  logic [3:0]       w_cnt_nxt;
  logic [3:0]       w_pos;
  logic [3:0]       w_ld_bytes;
  logic [5:0]       w_shift;
  logic [OUT_W-1:0] w_base;
  logic [OUT_W-1:0] w_word;
  logic [OUT_W-1:0] w_ld_data;

  // Input side is blocked only while a held word is refused by the consumer.
  assign w_stall    = (r_state == ST_HOLD) && !bp.out_ready;
  assign w_in_ready = bp.enb && !w_stall;
  assign w_acc      = bp.enb && bp.in_valid && w_in_ready;
  assign w_flush    = w_in_ready && (bp.flush || r_flush_pend);

  // Word size is sampled only on the first byte of a word; oversize modes fall back to 1.
  assign w_start    = w_acc && (r_cnt == 4'd0);
  assign w_mode_n   = mode_bytes(bp.mode);
  assign w_bad_mode = w_mode_n > 4'(MAX_BYTES);
  assign w_n        = w_start ? (w_bad_mode ? 4'd1 : w_mode_n) : r_n;

  // Byte k of an N-byte word goes to byte lane N-1-k, so partial words stay left-packed.
  assign w_cnt_inc  = r_cnt + 4'd1;
  assign w_pos      = w_n - w_cnt_inc;
  assign w_shift    = {w_pos[2:0], 3'b000};
  assign w_base     = (r_cnt == 4'd0) ? '0 : r_acc;
  assign w_word     = w_base | (OUT_W'(bp.in_data) << w_shift);

  assign w_complete = w_acc && (w_cnt_inc == w_n);
  assign w_load     = w_complete || (w_flush && (w_acc || (r_cnt != 4'd0)));
  assign w_ld_data  = w_acc ? w_word : r_acc;
  assign w_ld_bytes = w_acc ? w_cnt_inc : r_cnt;
  assign w_cnt_nxt  = w_load ? 4'd0 : (w_acc ? w_cnt_inc : r_cnt);

  // Assembly state: byte count, latched size, partial word, deferred flush, mode error pulse.
  always_ff @(posedge clk8) begin
    if (rst) begin
      r_cnt        <= 4'd0;
      r_n          <= 4'd1;
      r_acc        <= '0;
      r_flush_pend <= 1'b0;
      r_mode_err   <= 1'b0;
    end else if (bp.enb) begin
      r_cnt      <= w_cnt_nxt;
      r_mode_err <= w_start && w_bad_mode;
      if (w_start) r_n <= w_n;
      if (w_acc)   r_acc <= w_word;
      if (w_in_ready)    r_flush_pend <= 1'b0;
      else if (bp.flush) r_flush_pend <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk8) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: HOLD while the output register owns a word, else FILL/IDLE by byte count.
  always_comb begin
    w_state_nxt = r_state;
    if (bp.enb) begin
      if (w_load || w_stall)     w_state_nxt = ST_HOLD;
      else if (w_cnt_nxt != 4'd0) w_state_nxt = ST_FILL;
      else                       w_state_nxt = ST_IDLE;
    end
  end

  byte_packer_outreg #(.OUT_W(OUT_W)) u_outreg (
    .clk8        (clk8),
    .rst         (rst),
    .i_enb       (bp.enb),
    .i_load      (w_load),
    .i_data      (w_ld_data),
    .i_bytes     (w_ld_bytes),
    .i_out_ready (bp.out_ready),
    .o_valid     (bp.out_valid),
    .o_data      (bp.out_data),
    .o_bytes     (bp.out_bytes)
  );

  assign bp.in_ready = w_in_ready;
  assign bp.mode_err = r_mode_err;

endmodule

// File: tb/tb_byte_packer.sv
// Directed bench for byte_packer with MAX_BYTES = 4.
module tb_byte_packer;

  logic clk8 = 1'b0;
  logic rst  = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  byte_packer_if #(.MAX_BYTES(4)) bp ();

  byte_packer #(.MAX_BYTES(4)) dut (
    .clk8 (clk8),
    .rst  (rst),
    .bp   (bp)
  );

  always #5 clk8 = ~clk8;

  task automatic tick();
    @(posedge clk8);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bp.in_valid = 1'b1;
    bp.in_data  = b;
    tick();
    bp.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (bp.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bp.out_valid); end
    n_cmp++; if (bp.out_data !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", bp.out_data); end
    n_cmp++; if (bp.out_bytes !== 4'd0) begin n_bad++; $display("FAIL rst_bytes got %0d want 0", bp.out_bytes); end
    n_cmp++; if (bp.mode_err !== 1'b0) begin n_bad++; $display("FAIL rst_moderr got %b want 0", bp.mode_err); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bp.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_inready got %b want 1", bp.in_ready); end
  endtask

  task automatic test_mode2();
    bp.mode = 2'b01; bp.out_ready = 1'b1;
    send(8'hAA);
    n_cmp++; if (bp.out_valid !== 1'b0) begin n_bad++; $display("FAIL m2_early got %b want 0", bp.out_valid); end
    send(8'hBB);
    n_cmp++; if (bp.out_valid !== 1'b1) begin n_bad++; $display("FAIL m2_valid got %b want 1", bp.out_valid); end
    n_cmp++; if (bp.out_data !== 32'h0000AABB) begin n_bad++; $display("FAIL m2_data got %h want 0000aabb", bp.out_data); end
    n_cmp++; if (bp.out_bytes !== 4'd2) begin n_bad++; $display("FAIL m2_bytes got %0d want 2", bp.out_bytes); end
    tick();
    n_cmp++; if (bp.out_valid !== 1'b0) begin n_bad++; $display("FAIL m2_taken got %b want 0", bp.out_valid); end
  endtask

  task automatic test_stall();
    bp.mode = 2'b10; bp.out_ready = 1'b0;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    bp.in_valid = 1'b1; bp.in_data = 8'h99;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bp.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_inready[%0d] got %b want 0", i, bp.in_ready); end
      n_cmp++; if (bp.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got %b want 1", i, bp.out_valid); end
      n_cmp++; if (bp.out_data !== 32'h11223344) begin n_bad++; $display("FAIL stall_data[%0d] got %h want 11223344", i, bp.out_data); end
      tick();
    end
    bp.in_valid = 1'b0; bp.out_ready = 1'b1;
    tick();
    n_cmp++; if (bp.out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release got %b want 0", bp.out_valid); end
  endtask

  task automatic test_flush();
    bp.mode = 2'b10; bp.out_ready = 1'b1;
    send(8'h11); send(8'h22);
    bp.flush = 1'b1; tick(); bp.flush = 1'b0;
    n_cmp++; if (bp.out_valid !== 1'b1) begin n_bad++; $display("FAIL fl_valid got %b want 1", bp.out_valid); end
    n_cmp++; if (bp.out_data !== 32'h11220000) begin n_bad++; $display("FAIL fl_data got %h want 11220000", bp.out_data); end
    n_cmp++; if (bp.out_bytes !== 4'd2) begin n_bad++; $display("FAIL fl_bytes got %0d want 2", bp.out_bytes); end
    send(8'h33);
    n_cmp++; if (bp.out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_next1 got %b want 0", bp.out_valid); end
    send(8'h44); send(8'h55); send(8'h66);
    n_cmp++; if (bp.out_data !== 32'h33445566) begin n_bad++; $display("FAIL fl_next_data got %h want 33445566", bp.out_data); end
    n_cmp++; if (bp.out_bytes !== 4'd4) begin n_bad++; $display("FAIL fl_next_bytes got %0d want 4", bp.out_bytes); end
  endtask

  task automatic test_flush_with_byte();
    send(8'h11);
    bp.flush = 1'b1;
    send(8'h22);
    bp.flush = 1'b0;
    n_cmp++; if (bp.out_data !== 32'h11220000) begin n_bad++; $display("FAIL flb_data got %h want 11220000", bp.out_data); end
    n_cmp++; if (bp.out_bytes !== 4'd2) begin n_bad++; $display("FAIL flb_bytes got %0d want 2", bp.out_bytes); end
    tick();
    bp.flush = 1'b1; tick(); bp.flush = 1'b0;
    n_cmp++; if (bp.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty got %b want 0", bp.out_valid); end
  endtask

  task automatic test_flush_pending();
    bp.mode = 2'b10; bp.out_ready = 1'b0;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    bp.flush = 1'b1; tick(); bp.flush = 1'b0; tick();
    n_cmp++; if (bp.out_data !== 32'h11223344) begin n_bad++; $display("FAIL pend_held got %h want 11223344", bp.out_data); end
    bp.out_ready = 1'b1;
    send(8'h77);
    n_cmp++; if (bp.out_valid !== 1'b1) begin n_bad++; $display("FAIL pend_valid got %b want 1", bp.out_valid); end
    n_cmp++; if (bp.out_data !== 32'h77000000) begin n_bad++; $display("FAIL pend_data got %h want 77000000", bp.out_data); end
    n_cmp++; if (bp.out_bytes !== 4'd1) begin n_bad++; $display("FAIL pend_bytes got %0d want 1", bp.out_bytes); end
    tick();
    n_cmp++; if (bp.out_valid !== 1'b0) begin n_bad++; $display("FAIL pend_taken got %b want 0", bp.out_valid); end
  endtask

  task automatic test_enable();
    bp.mode = 2'b00; bp.enb = 1'b0;
    #1;
    n_cmp++; if (bp.in_ready !== 1'b0) begin n_bad++; $display("FAIL enb_inready got %b want 0", bp.in_ready); end
    send(8'h33);
    n_cmp++; if (bp.out_valid !== 1'b0) begin n_bad++; $display("FAIL enb_hold got %b want 0", bp.out_valid); end
    bp.enb = 1'b1;
    send(8'h44);
    n_cmp++; if (bp.out_data !== 32'h00000044) begin n_bad++; $display("FAIL m1_data got %h want 00000044", bp.out_data); end
    tick();
  endtask

  task automatic test_mode_err();
    bp.mode = 2'b11;
    send(8'h5A);
    n_cmp++; if (bp.mode_err !== 1'b1) begin n_bad++; $display("FAIL merr_pulse got %b want 1", bp.mode_err); end
    n_cmp++; if (bp.out_data !== 32'h0000005A) begin n_bad++; $display("FAIL merr_data got %h want 0000005a", bp.out_data); end
    n_cmp++; if (bp.out_bytes !== 4'd1) begin n_bad++; $display("FAIL merr_bytes got %0d want 1", bp.out_bytes); end
    tick();
    n_cmp++; if (bp.mode_err !== 1'b0) begin n_bad++; $display("FAIL merr_clear got %b want 0", bp.mode_err); end
  endtask

  task automatic test_mode_switch();
    bp.mode = 2'b01;
    send(8'hA1);
    bp.mode = 2'b10;
    send(8'hB2);
    n_cmp++; if (bp.out_data !== 32'h0000A1B2) begin n_bad++; $display("FAIL msw_data got %h want 0000a1b2", bp.out_data); end
    n_cmp++; if (bp.out_bytes !== 4'd2) begin n_bad++; $display("FAIL msw_bytes got %0d want 2", bp.out_bytes); end
    send(8'hC3); send(8'hD4);
    n_cmp++; if (bp.out_valid !== 1'b0) begin n_bad++; $display("FAIL msw_mid got %b want 0", bp.out_valid); end
    send(8'hE5); send(8'hF6);
    n_cmp++; if (bp.out_data !== 32'hC3D4E5F6) begin n_bad++; $display("FAIL msw_w4 got %h want c3d4e5f6", bp.out_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    bp.mode = 2'b10; bp.out_ready = 1'b1;
    send(8'h11); send(8'h22); send(8'h33);
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (bp.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstw_valid got %b want 0", bp.out_valid); end
    n_cmp++; if (bp.out_data !== 32'h0) begin n_bad++; $display("FAIL rstw_data got %h want 0", bp.out_data); end
    send(8'h44);
    n_cmp++; if (bp.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstw_stale got %b want 0", bp.out_valid); end
    send(8'h55); send(8'h66); send(8'h77);
    n_cmp++; if (bp.out_data !== 32'h44556677) begin n_bad++; $display("FAIL rstw_fresh got %h want 44556677", bp.out_data); end
    bp.out_ready = 1'b0;
    tick();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (bp.out_valid !== 1'b0) begin n_bad++; $display("FAIL rsth_valid got %b want 0", bp.out_valid); end
    n_cmp++; if (bp.out_data !== 32'h0) begin n_bad++; $display("FAIL rsth_data got %h want 0", bp.out_data); end
    n_cmp++; if (bp.out_bytes !== 4'd0) begin n_bad++; $display("FAIL rsth_bytes got %0d want 0", bp.out_bytes); end
    bp.out_ready = 1'b1;
    send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
    n_cmp++; if (bp.out_data !== 32'h0A0B0C0D) begin n_bad++; $display("FAIL rsth_fresh got %h want 0a0b0c0d", bp.out_data); end
    n_cmp++; if (bp.out_bytes !== 4'd4) begin n_bad++; $display("FAIL rsth_bytes4 got %0d want 4", bp.out_bytes); end
  endtask

  initial begin
    bp.enb = 1'b1; bp.in_valid = 1'b0; bp.in_data = 8'h00;
    bp.mode = 2'b00; bp.flush = 1'b0; bp.out_ready = 1'b1;
    test_reset();
    test_mode2();
    test_stall();
    test_flush();
    test_flush_with_byte();
    test_flush_pending();
    test_enable();
    test_mode_err();
    test_mode_switch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 Parameter MAX_BYTES, default 4, SHALL set the widest output word in bytes; legal values are 1, 2, 4 or 8.
REQ-002 Parameter OUT_W, default 8*MAX_BYTES, SHALL set the output data width and is derived, not overridden.
REQ-003 clk8  input  1  byte clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high, sampled on clk8.
REQ-005 enb  input  1  global enable; when low, all state SHALL hold and in_ready SHALL be 0.
REQ-006 in_valid  input  1  in_data carries a byte this cycle.
REQ-007 in_data  input  8  serial byte stream.
REQ-008 in_ready  output  1  the block accepts a byte this cycle.
REQ-009 mode  input  2  word size select: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = 8 bytes.
REQ-010 flush  input  1  emit the partial word now.
REQ-011 out_valid  output  1  out_data holds a word.
REQ-012 out_ready  input  1  consumer takes the word.
REQ-013 out_data  output  OUT_W  assembled word, right-aligned, zero-extended above the active width.
REQ-014 out_bytes  output  4  number of valid bytes in out_data (1..8).
REQ-015 mode_err  output  1  one-cycle pulse when an unsupported mode is latched.

Function
REQ-016 A byte SHALL be accepted when enb && in_valid && in_ready.
REQ-017 in_ready SHALL equal enb && !(out_valid && !out_ready).
REQ-018 The active word size N SHALL be latched from mode only when the byte counter cnt is 0 and a byte is accepted. Mode changes while cnt != 0 SHALL take effect at the next word start.
REQ-019 A mode selecting N > MAX_BYTES SHALL latch N = 1 and SHALL pulse mode_err for one cycle.
REQ-020 Byte order SHALL be MSB-first: the k-th accepted byte (k = 0..N-1) lands in bits [8*(N-k)-1 : 8*(N-k-1)].
REQ-021 cnt SHALL increment per accepted byte and wrap to 0 on the byte that completes the word.
REQ-022 When the completing byte is accepted, the word SHALL be loaded into out_data on the same edge. out_valid SHALL rise the next cycle, giving a latency of 1 clk8 from the last byte. out_bytes SHALL equal N.
REQ-023 out_valid SHALL stay high, and out_data/out_bytes SHALL stay stable, until a cycle with out_ready high. out_valid SHALL then clear, unless a new word loads on that same edge, in which case out_valid stays 1.
REQ-024 When flush is high and cnt != 0, the partial word SHALL be loaded with the unfilled low bytes set to 0 and out_bytes set to cnt. cnt SHALL return to 0.
REQ-025 When flush and an accepted byte coincide, the byte SHALL be included in the word before it is emitted. out_bytes SHALL be cnt+1, or N if that byte completes the word.
REQ-026 A flush with cnt = 0 and no accepted byte SHALL have no effect.
REQ-027 A flush while the output is stalled (in_ready = 0) SHALL be held pending and executed on the first cycle the output frees.
REQ-028 Control FSM states: IDLE (cnt = 0, out empty), FILL (0 < cnt < N), HOLD (out_valid && !out_ready). HOLD SHALL return to IDLE or FILL per cnt when the word is taken.

Reset
REQ-029 On rst, the following SHALL be cleared in one clk8 edge regardless of enb: cnt = 0, N = 1, out_valid = 0, out_data = 0, out_bytes = 0, mode_err = 0, pending flush = 0, FSM = IDLE.
REQ-030 A reset mid-word or mid-stall SHALL discard the partial word and the held word without emitting either.

Structure
REQ-031 Package byte_packer_pkg SHALL hold the mode encodings, the FSM state enumeration, and the function mapping mode to byte count.
REQ-032 One sub-module, byte_packer_outreg, SHALL implement the output holding register and the valid/ready logic. The assembly datapath and FSM stay in byte_packer.

Verification
REQ-033 MAX_BYTES=4, mode=01, bytes AA,BB: out_data = 0000_AABB, out_bytes = 2, out_valid asserted 1 cycle after BB.
REQ-034 mode=10, bytes 11,22,33,44 with out_ready held low for 3 cycles: in_ready = 0 and out_data = 1122_3344 stable across the stall, then released on out_ready.
REQ-035 mode=10, bytes 11,22 then flush: out_data = 1122_0000, out_bytes = 2; the next word starts with cnt = 0.
REQ-036 MAX_BYTES=4, mode=11, byte 5A: mode_err pulses once, out_data = 0000_005A, out_bytes = 1.
REQ-037 mode=01 with byte A1 accepted, then mode switched to 10: the next byte completes a 2-byte word (A1xx), and the 4-byte size applies from the following byte.
REQ-038 rst asserted after 3 of 4 bytes and during a HOLD: no word is emitted, all outputs are 0 on the next cycle, and a fresh 4-byte word assembles correctly afterwards.
